// File: rtl/onchip_mem_ring_writer.sv
// Purpose: round-robin multi-channel writer that appends words to NUM_CH ring regions of the on-chip memory s2 port.
// Latency: one cycle from accept to the registered mem_write strobe; irq is registered from the current ring levels.
// Backpressure: in_ready drops for a full ring; with ONCHIP_RING_DROP_ON_FULL_EN defined, full words are accepted, dropped and counted.
module onchip_mem_ring_writer #(
   parameter int NUM_CH      = 4,
   parameter int DATA_W      = 64,
   parameter int ADDR_W      = 15,
   parameter int REGION_LOG2 = 13,
   parameter int IRQ_THRESH  = 256
) (
   input  logic                          clk_clk,
   input  logic                          reset_reset,
   input  logic                          enable,
   input  logic [NUM_CH-1:0]             in_valid,
   output logic [NUM_CH-1:0]             in_ready,
   input  logic [NUM_CH*DATA_W-1:0]      in_data,
   input  logic [NUM_CH*DATA_W/8-1:0]    in_be,
   input  logic [NUM_CH*REGION_LOG2-1:0] rd_ptr,
   output logic [NUM_CH*REGION_LOG2-1:0] wr_ptr,
   output logic [NUM_CH*REGION_LOG2-1:0] level,
   output logic                          irq,
   output logic [ADDR_W-1:0]             mem_address,
   output logic                          mem_chipselect,
   output logic                          mem_clken,
   output logic                          mem_write,
   output logic [DATA_W-1:0]             mem_writedata,
   output logic [DATA_W/8-1:0]           mem_byteenable
`ifdef ONCHIP_RING_DROP_ON_FULL_EN
   ,
   output logic [NUM_CH*16-1:0]          drop_cnt
`endif
);

   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int BE_W = DATA_W / 8;
   localparam logic [REGION_LOG2-1:0] THRESH  = REGION_LOG2'(IRQ_THRESH);
   localparam logic [CH_W-1:0]        LAST_CH = CH_W'(NUM_CH - 1);

   // producer index per ring
   logic [REGION_LOG2-1:0] wr_q [NUM_CH];
   // first channel examined by the next arbitration (channel 0 after reset)
   logic [CH_W-1:0]        rr_q;

   logic [DATA_W-1:0]      dat_a [NUM_CH];
   logic [BE_W-1:0]        be_a  [NUM_CH];
   logic [NUM_CH-1:0]      full;
   logic [NUM_CH-1:0]      over;
   logic [NUM_CH-1:0]      elig;
   logic [NUM_CH-1:0]      grant;
   logic [CH_W-1:0]        gidx;
   logic [CH_W-1:0]        cidx;
   logic                   xfer;
   logic                   wr_en;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ring
      logic [REGION_LOG2-1:0] rd_i;
      logic [REGION_LOG2-1:0] wr_inc;
      logic [REGION_LOG2-1:0] lvl;

      // ring occupancy is plain modular distance; a consumer ahead of the producer is not flagged
      assign rd_i    = rd_ptr[i*REGION_LOG2 +: REGION_LOG2];
      assign wr_inc  = wr_q[i] + REGION_LOG2'(1);
      assign lvl     = wr_q[i] - rd_i;
      assign full[i] = (wr_inc == rd_i);
      assign over[i] = (lvl >= THRESH);
      assign dat_a[i] = in_data[i*DATA_W +: DATA_W];
      assign be_a[i]  = in_be[i*BE_W +: BE_W];
      assign wr_ptr[i*REGION_LOG2 +: REGION_LOG2] = wr_q[i];
      assign level[i*REGION_LOG2 +: REGION_LOG2]  = lvl;
   end

`ifdef ONCHIP_RING_DROP_ON_FULL_EN
   // full rings still compete so their words can be consumed and discarded
   assign elig  = in_valid;
   assign wr_en = xfer & ~full[gidx];
`else
   // full rings sit out arbitration, which backpressures their source
   assign elig  = in_valid & ~full;
   assign wr_en = xfer;
`endif

   // round-robin pick of the first eligible channel starting at rr_q
   always_comb begin
      grant = '0;
      gidx  = '0;
      cidx  = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         cidx = CH_W'((int'(rr_q) + k) % NUM_CH);
         if (elig[cidx] && (grant == '0)) begin
            grant[cidx] = 1'b1;
            gidx        = cidx;
         end
      end
   end

   assign in_ready = enable ? grant : '0;
   assign xfer     = |in_ready;

   // ring pointers, arbitration pointer, interrupt and the registered s2 write port
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            wr_q[i] <= '0;
         end
         rr_q           <= '0;
         irq            <= 1'b0;
         mem_write      <= 1'b0;
         mem_chipselect <= 1'b0;
         mem_clken      <= 1'b0;
         mem_address    <= '0;
         mem_writedata  <= '0;
         mem_byteenable <= '0;
      end else begin
         mem_write      <= wr_en;
         mem_chipselect <= wr_en;
         mem_clken      <= wr_en;
         irq            <= |over;
         if (xfer) begin
            rr_q <= (gidx == LAST_CH) ? '0 : gidx + CH_W'(1);
         end
         if (wr_en) begin
            wr_q[gidx]     <= wr_q[gidx] + REGION_LOG2'(1);
            mem_address    <= ADDR_W'({gidx, wr_q[gidx]});
            mem_writedata  <= dat_a[gidx];
            mem_byteenable <= be_a[gidx];
         end
      end
   end

`ifdef ONCHIP_RING_DROP_ON_FULL_EN
   logic [15:0] drop_q [NUM_CH];

   // saturating count of words discarded because their ring was full
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            drop_q[i] <= '0;
         end
      end else if (xfer && full[gidx] && (drop_q[gidx] != 16'hFFFF)) begin
         drop_q[gidx] <= drop_q[gidx] + 16'd1;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_drop
      assign drop_cnt[i*16 +: 16] = drop_q[i];
   end
`endif

endmodule

// File: tb/tb_onchip_mem_ring_writer.sv
// Bench for onchip_mem_ring_writer: constant vector table, directed ring corner cases and random traffic against a ring model.
// Inputs change one time unit after the rising edge; outputs are sampled one unit after the edge or just before it.
// Set ONCHIP_RING_DROP_ON_FULL_EN consistently for RTL and bench to cover the drop-on-full variant.
module tb_onchip_mem_ring_writer;
   localparam int NUM_CH = 4;
   localparam int DATA_W = 64;
   localparam int ADDR_W = 15;
   localparam int RL     = 13;
   localparam int THR    = 256;
   localparam int RSZ    = 1 << RL;

   logic                     clk_clk = 1'b0;
   logic                     reset_reset;
   logic                     enable;
   logic [NUM_CH-1:0]        in_valid;
   logic [NUM_CH-1:0]        in_ready;
   logic [NUM_CH*DATA_W-1:0] in_data;
   logic [NUM_CH*8-1:0]      in_be;
   logic [NUM_CH*RL-1:0]     rd_ptr;
   logic [NUM_CH*RL-1:0]     wr_ptr;
   logic [NUM_CH*RL-1:0]     level;
   logic                     irq;
   logic [ADDR_W-1:0]        mem_address;
   logic                     mem_chipselect;
   logic                     mem_clken;
   logic                     mem_write;
   logic [DATA_W-1:0]        mem_writedata;
   logic [7:0]               mem_byteenable;
`ifdef ONCHIP_RING_DROP_ON_FULL_EN
   logic [NUM_CH*16-1:0]     drop_cnt;
`endif

   int n_vec = 0;
   int n_err = 0;

   // reference state: ring producer counts, next-priority channel, last issued write
   int                m_wr   [NUM_CH];
   int                m_drop [NUM_CH];
   int                m_prio;
   logic              m_we;
   logic              m_irq;
   logic [ADDR_W-1:0] m_addr;
   logic [63:0]       m_data;
   logic [7:0]        m_be;

   typedef struct {
      logic [3:0] v;
      logic       en;
      logic [3:0] rdy;
      logic       we;
      int         addr;
   } vec_t;
   vec_t tbl [9];

   onchip_mem_ring_writer #(
      .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REGION_LOG2(RL), .IRQ_THRESH(THR)
   ) dut (
      .clk_clk        (clk_clk),
      .reset_reset    (reset_reset),
      .enable         (enable),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .in_be          (in_be),
      .rd_ptr         (rd_ptr),
      .wr_ptr         (wr_ptr),
      .level          (level),
      .irq            (irq),
      .mem_address    (mem_address),
      .mem_chipselect (mem_chipselect),
      .mem_clken      (mem_clken),
      .mem_write      (mem_write),
      .mem_writedata  (mem_writedata),
      .mem_byteenable (mem_byteenable)
`ifdef ONCHIP_RING_DROP_ON_FULL_EN
      ,
      .drop_cnt       (drop_cnt)
`endif
   );

   always #5 clk_clk = ~clk_clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int rd_of(input int c);
      return int'(rd_ptr[c*RL +: RL]);
   endfunction

   function automatic int lvl_of(input int c);
      return (m_wr[c] - rd_of(c)) & (RSZ - 1);
   endfunction

   function automatic bit is_full(input int c);
      return ((m_wr[c] + 1) % RSZ) == rd_of(c);
   endfunction

   // channel the reference arbiter picks this cycle, -1 for none
   function automatic int model_grant();
      for (int k = 0; k < NUM_CH; k++) begin
         int c;
         c = (m_prio + k) % NUM_CH;
`ifdef ONCHIP_RING_DROP_ON_FULL_EN
         if (enable && in_valid[c]) return c;
`else
         if (enable && in_valid[c] && !is_full(c)) return c;
`endif
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         m_wr[c]   = 0;
         m_drop[c] = 0;
      end
      m_prio = 0;
      m_we   = 1'b0;
      m_irq  = 1'b0;
      m_addr = '0;
      m_data = '0;
      m_be   = '0;
   endtask

   task automatic do_reset();
      @(negedge clk_clk);
      reset_reset = 1'b1;
      enable      = 1'b1;
      in_valid    = '0;
      in_data     = '0;
      in_be       = '0;
      rd_ptr      = '0;
      #2;
      chk("rst_mem_write", 64'(mem_write), 0);
      chk("rst_mem_chipselect", 64'(mem_chipselect), 0);
      chk("rst_mem_address", 64'(mem_address), 0);
      chk("rst_wr_ptr", 64'(wr_ptr), 0);
      chk("rst_irq", 64'(irq), 0);
      model_reset();
      reset_reset = 1'b0;
   endtask

   // one clock: check combinational outputs, advance the model across the edge, check registered outputs
   task automatic step();
      int          g;
      bit          any_over;
      bit          g_full;
      logic [63:0] d;
      logic [7:0]  b;
      #1;
      g = model_grant();
      chk("in_ready", 64'(in_ready), (g < 0) ? 64'd0 : (64'd1 << g));
      any_over = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         chk("wr_ptr", 64'(wr_ptr[c*RL +: RL]), 64'(m_wr[c]));
         chk("level", 64'(level[c*RL +: RL]), 64'(lvl_of(c)));
         if (lvl_of(c) >= THR) any_over = 1'b1;
      end
      g_full = (g >= 0) && is_full(g);
      d = (g >= 0) ? in_data[g*DATA_W +: DATA_W] : 64'd0;
      b = (g >= 0) ? in_be[g*8 +: 8] : 8'd0;
      @(posedge clk_clk);
      m_we = 1'b0;
      if (g >= 0) begin
         m_prio = (g + 1) % NUM_CH;
         if (g_full) begin
            if (m_drop[g] < 65535) m_drop[g]++;
         end else begin
            m_we   = 1'b1;
            m_addr = ADDR_W'((g << RL) | m_wr[g]);
            m_data = d;
            m_be   = b;
            m_wr[g] = (m_wr[g] + 1) % RSZ;
         end
      end
      m_irq = any_over;
      #1;
      chk("mem_write", 64'(mem_write), 64'(m_we));
      chk("mem_chipselect", 64'(mem_chipselect), 64'(m_we));
      chk("mem_clken", 64'(mem_clken), 64'(m_we));
      chk("mem_address", 64'(mem_address), 64'(m_addr));
      chk("mem_writedata", mem_writedata, m_data);
      chk("mem_byteenable", 64'(mem_byteenable), 64'(m_be));
      chk("irq", 64'(irq), 64'(m_irq));
`ifdef ONCHIP_RING_DROP_ON_FULL_EN
      for (int c = 0; c < NUM_CH; c++) begin
         chk("drop_cnt", 64'(drop_cnt[c*16 +: 16]), 64'(m_drop[c]));
      end
`endif
   endtask

   initial begin
      // arbitration table from reset: {valid, enable, in_ready, mem_write next, mem_address next}
      tbl[0] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 0};
      tbl[1] = '{4'b1111, 1'b1, 4'b0010, 1'b1, 8192};
      tbl[2] = '{4'b1111, 1'b0, 4'b0000, 1'b0, 8192};
      tbl[3] = '{4'b1111, 1'b1, 4'b0100, 1'b1, 16384};
      tbl[4] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 24576};
      tbl[5] = '{4'b1001, 1'b1, 4'b0001, 1'b1, 1};
      tbl[6] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 24577};
      tbl[7] = '{4'b0110, 1'b1, 4'b0010, 1'b1, 8193};
      tbl[8] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 8193};

      reset_reset = 1'b1;
      do_reset();
      for (int i = 0; i < 9; i++) begin
         in_valid = tbl[i].v;
         enable   = tbl[i].en;
         #1;
         chk($sformatf("tbl%0d_ready", i), 64'(in_ready), 64'(tbl[i].rdy));
         @(posedge clk_clk);
         #1;
         chk($sformatf("tbl%0d_write", i), 64'(mem_write), 64'(tbl[i].we));
         chk($sformatf("tbl%0d_addr", i), 64'(mem_address), 64'(tbl[i].addr));
      end

      // three words on channel 0
      do_reset();
      in_valid = 4'b0001;
      in_be    = '1;
      for (int i = 0; i < 3; i++) begin
         in_data[63:0] = 64'hD000_0000_0000_0000 + 64'(i);
         step();
         chk("ch0_addr", 64'(mem_address), 64'(i));
         chk("ch0_data", mem_writedata, 64'hD000_0000_0000_0000 + 64'(i));
      end
      in_valid = '0;
      step();
      chk("ch0_wr_ptr", 64'(wr_ptr[RL-1:0]), 3);
      chk("ch0_level", 64'(level[RL-1:0]), 3);

      // all channels valid: strict rotation
      do_reset();
      in_valid = '1;
      for (int i = 0; i < 8; i++) begin
         step();
         if (i == 2) chk("ch2_first_addr", 64'(mem_address), 16384);
      end

      // fill ring 1, then release five slots and wrap
      do_reset();
      in_valid = 4'b0010;
      repeat (RSZ - 1) step();
      chk("ring1_full_ready", 64'(in_ready[1]), 0);
      chk("ring1_full_wr_ptr", 64'(wr_ptr[RL +: RL]), RSZ - 1);
      rd_ptr[RL +: RL] = 13'd5;
      repeat (6) step();
      chk("ring1_wrap_wr_ptr", 64'(wr_ptr[RL +: RL]), 4);
      chk("ring1_refull_ready", 64'(in_ready[1]), 0);

      // interrupt threshold on ring 3
      do_reset();
      in_valid = 4'b1000;
      repeat (THR) step();
      chk("irq_at_last_accept", 64'(irq), 0);
      in_valid = '0;
      step();
      chk("irq_raised", 64'(irq), 1);
      rd_ptr[3*RL +: RL] = 13'd1;
      step();
      chk("irq_cleared", 64'(irq), 0);

      // reset right after an accept discards the pending write
      do_reset();
      in_valid = 4'b0100;
      step();
      chk("pre_rst_write", 64'(mem_write), 1);
      reset_reset = 1'b1;
      #1;
      chk("mid_rst_write", 64'(mem_write), 0);
      chk("mid_rst_wr_ptr", 64'(wr_ptr), 0);
      reset_reset = 1'b0;
      in_valid = '1;
      #1;
      chk("post_rst_grant", 64'(in_ready), 1);
      model_reset();
      step();

`ifdef ONCHIP_RING_DROP_ON_FULL_EN
      // full ring 0 swallows words without writing
      do_reset();
      rd_ptr[RL-1:0] = 13'd1;
      in_valid = 4'b0001;
      #1;
      chk("drop_ready", 64'(in_ready), 1);
      repeat (3) step();
      chk("drop_cnt0", 64'(drop_cnt[15:0]), 3);
      chk("drop_wr_ptr", 64'(wr_ptr[RL-1:0]), 0);
      chk("drop_no_write", 64'(mem_write), 0);
`endif

      // random traffic with a moving consumer
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         in_valid = NUM_CH'($urandom);
         enable   = ($urandom_range(0, 7) != 0);
         for (int c = 0; c < NUM_CH; c++) begin
            in_data[c*DATA_W +: DATA_W] = {$urandom, $urandom};
            in_be[c*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            case ($urandom_range(0, 31))
               0: rd_ptr[c*RL +: RL] = RL'(m_wr[c]);
               1: rd_ptr[c*RL +: RL] = RL'((m_wr[c] + 1) % RSZ);
               2: rd_ptr[c*RL +: RL] = RL'($urandom);
               default: ;
            endcase
         end
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
